// File: rtl/fm_sample_demod.sv
// fm_sample_demod: post-detection FM demodulator for the 200 MHz receive domain.
// Averages frequency-counter samples over a 2^AVG_LOG2 boxcar, removes the
// nominal carrier count and emits a saturated signed deviation word, a
// carrier-present flag and (optionally) a 1-bit PWM audio output.
//
// Optional feature macro: FM_DEMOD_PWM_EN
//   defined   : free-running PWM counter drives audio_pwm_o
//   undefined : no PWM counter, audio_pwm_o tied to 0
//
// Ports:
//   clk_200M          in   200 MHz receive clock
//   reset_n_200M      in   asynchronous active-low reset
//   sample_i          in   count sample from the frequency counter
//   sample_valid_i    in   one-cycle strobe qualifying sample_i
//   deviation_o       out  signed (mean - CENTER), saturated to OUT_WIDTH
//   deviation_valid_o out  one-cycle pulse, deviation_o updated
//   carrier_present_o out  window full and carrier not timed out
//   audio_pwm_o       out  PWM of deviation_o (offset binary)
module fm_sample_demod #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned AVG_LOG2     = 3,
    parameter int unsigned CENTER       = 200,
    parameter int unsigned OUT_WIDTH    = 8,
    parameter int unsigned TIMEOUT      = 4095
) (
    input  logic                    clk_200M,
    input  logic                    reset_n_200M,
    input  logic [SAMPLE_WIDTH-1:0] sample_i,
    input  logic                    sample_valid_i,
    output logic [OUT_WIDTH-1:0]    deviation_o,
    output logic                    deviation_valid_o,
    output logic                    carrier_present_o,
    output logic                    audio_pwm_o
);

    localparam int unsigned DEPTH  = 1 << AVG_LOG2;
    localparam int unsigned SUM_W  = SAMPLE_WIDTH + AVG_LOG2;
    localparam int unsigned DIFF_W = SAMPLE_WIDTH + 2;
    localparam int unsigned PTR_W  = AVG_LOG2;
    localparam int unsigned FILL_W = AVG_LOG2 + 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic signed [DIFF_W-1:0] CENTER_S = DIFF_W'(CENTER);
    localparam logic signed [DIFF_W-1:0] DEV_MAX  = DIFF_W'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [DIFF_W-1:0] DEV_MIN  = ~DEV_MAX;

    logic [DEPTH-1:0][SAMPLE_WIDTH-1:0] buf_q, buf_d;
    logic [SUM_W-1:0]                   sum_q, sum_d;
    logic [PTR_W-1:0]                   wptr_q, wptr_d;
    logic [FILL_W-1:0]                  fill_q, fill_d;
    logic [TMO_W-1:0]                   tmo_q, tmo_d;
    logic                               s1_valid_q, s1_valid_d;
    logic [OUT_WIDTH-1:0]               sat_q, sat_d;
    logic                               s2_valid_q, s2_valid_d;
    logic [OUT_WIDTH-1:0]               deviation_q, deviation_d;
    logic                               dev_valid_q, dev_valid_d;
    logic                               carrier_q, carrier_d;

    logic                               flush_c;
    logic [SAMPLE_WIDTH-1:0]            mean_c;
    logic signed [DIFF_W-1:0]           diff_c;

    // Idle long enough with no sample arriving this cycle: drop the carrier.
    assign flush_c = (tmo_q == TMO_W'(TIMEOUT)) && !sample_valid_i;

    assign mean_c = SAMPLE_WIDTH'(sum_q >> AVG_LOG2);
    assign diff_c = $signed({2'b00, mean_c}) - CENTER_S;

    // Next-state: window update, clamp pipeline, output registers.
    always_comb begin
        buf_d       = buf_q;
        sum_d       = sum_q;
        wptr_d      = wptr_q;
        fill_d      = fill_q;
        tmo_d       = tmo_q;
        s1_valid_d  = 1'b0;
        sat_d       = sat_q;
        s2_valid_d  = s1_valid_q;
        deviation_d = deviation_q;
        dev_valid_d = s2_valid_q;
        carrier_d   = carrier_q;

        // Stage 1: circular window and running sum
        if (sample_valid_i) begin
            buf_d[wptr_q] = sample_i;
            sum_d         = sum_q + SUM_W'(sample_i) - SUM_W'(buf_q[wptr_q]);
            wptr_d        = wptr_q + 1'b1;
            if (fill_q != FILL_W'(DEPTH)) begin
                fill_d = fill_q + 1'b1;
            end
            // The sample that completes the window is the first to report.
            s1_valid_d = (fill_q >= FILL_W'(DEPTH - 1));
            tmo_d      = '0;
        end else if (tmo_q != TMO_W'(TIMEOUT)) begin
            tmo_d = tmo_q + 1'b1;
        end

        // Stage 2: mean - CENTER, clamped to the output range
        if (s1_valid_q) begin
            if (diff_c > DEV_MAX) begin
                sat_d = OUT_WIDTH'(DEV_MAX);
            end else if (diff_c < DEV_MIN) begin
                sat_d = OUT_WIDTH'(DEV_MIN);
            end else begin
                sat_d = diff_c[OUT_WIDTH-1:0];
            end
        end

        // Output stage
        if (s2_valid_q) begin
            deviation_d = sat_q;
            carrier_d   = 1'b1;
        end

        if (flush_c) begin
            buf_d       = '0;
            sum_d       = '0;
            wptr_d      = '0;
            fill_d      = '0;
            s1_valid_d  = 1'b0;
            s2_valid_d  = 1'b0;
            dev_valid_d = 1'b0;
            deviation_d = '0;
            carrier_d   = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk_200M or negedge reset_n_200M) begin
        if (!reset_n_200M) begin
            buf_q       <= '0;
            sum_q       <= '0;
            wptr_q      <= '0;
            fill_q      <= '0;
            tmo_q       <= '0;
            s1_valid_q  <= 1'b0;
            sat_q       <= '0;
            s2_valid_q  <= 1'b0;
            deviation_q <= '0;
            dev_valid_q <= 1'b0;
            carrier_q   <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            sum_q       <= sum_d;
            wptr_q      <= wptr_d;
            fill_q      <= fill_d;
            tmo_q       <= tmo_d;
            s1_valid_q  <= s1_valid_d;
            sat_q       <= sat_d;
            s2_valid_q  <= s2_valid_d;
            deviation_q <= deviation_d;
            dev_valid_q <= dev_valid_d;
            carrier_q   <= carrier_d;
        end
    end

    assign deviation_o       = deviation_q;
    assign deviation_valid_o = dev_valid_q;
    assign carrier_present_o = carrier_q;

`ifdef FM_DEMOD_PWM_EN
    logic [OUT_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                 audio_q, audio_d;
    logic [OUT_WIDTH-1:0] offset_c;

    // Offset-binary view of the deviation: 0 maps to half scale (50 % duty).
    assign offset_c = deviation_q + OUT_WIDTH'(1 << (OUT_WIDTH - 1));

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        audio_d   = (pwm_cnt_q < offset_c);
    end

    always_ff @(posedge clk_200M or negedge reset_n_200M) begin
        if (!reset_n_200M) begin
            pwm_cnt_q <= '0;
            audio_q   <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            audio_q   <= audio_d;
        end
    end

    assign audio_pwm_o = audio_q;
`else
    assign audio_pwm_o = 1'b0;
`endif

endmodule
